// File: rtl/vip_bin_frame_source.sv
// Binary video source: replays a packed 1-bit bitmap from a synchronous RAM as a
// vsync/href/clken/Bit stream, owning frame/line timing and the word prefetch.
module vip_bin_frame_source #(
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480,
  parameter int H_BLANK   = 16,
  parameter int V_FRONT   = 4,
  parameter int V_BACK    = 4,
  parameter int FRAME_GAP = 8,
  parameter int ADDR_W    = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              continuous,
  output logic              busy,
  output logic              frame_done,
  output logic [7:0]        frame_cnt,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [15:0]       rd_data,
  output logic              post_frame_vsync,
  output logic              post_frame_href,
  output logic              post_frame_clken,
  output logic              post_img_Bit,
  output logic [2:0]        dbg_state
);

  localparam int LINE = IMG_HDISP + H_BLANK;
  localparam int HMAX = (LINE > FRAME_GAP) ? LINE : FRAME_GAP;
  localparam int HW   = $clog2(HMAX);
  localparam int VM0  = (IMG_VDISP > V_FRONT) ? IMG_VDISP : V_FRONT;
  localparam int VMAX = (VM0 > V_BACK) ? VM0 : V_BACK;
  localparam int VW   = $clog2(VMAX + 1);

  if (H_BLANK < 2 || V_FRONT < 1 || FRAME_GAP < 1 || IMG_HDISP < 16 ||
      (IMG_HDISP % 16) != 0) begin : g_param_check
    $error("vip_bin_frame_source: illegal parameter set");
  end

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    VS_LEAD = 3'd1,
    ACTIVE  = 3'd2,
    VS_TAIL = 3'd3,
    GAP     = 3'd4
  } state_t;

  state_t            state, state_n;
  logic [HW-1:0]     h_cnt, h_n;
  logic [VW-1:0]     v_cnt, v_n;
  logic [ADDR_W-1:0] ptr, ptr_cur;
  logic [15:0]       sh;
  logic              line_end;
  logic              vsync_n, href_n, word_first, rd_n, done_n, new_frame;

  assign dbg_state = state;

  // Next state and line/phase counters.
  always_comb begin
    state_n  = state;
    h_n      = h_cnt;
    v_n      = v_cnt;
    line_end = (h_cnt == HW'(LINE - 1));
    case (state)
      IDLE: begin
        if (start) begin
          state_n = VS_LEAD;
          h_n     = '0;
          v_n     = '0;
        end
      end
      VS_LEAD: begin
        if (line_end) begin
          h_n = '0;
          if (v_cnt == VW'(V_FRONT - 1)) begin
            state_n = ACTIVE;
            v_n     = '0;
          end else begin
            v_n = v_cnt + 1'b1;
          end
        end else begin
          h_n = h_cnt + 1'b1;
        end
      end
      ACTIVE: begin
        if (line_end) begin
          h_n = '0;
          if (v_cnt == VW'(IMG_VDISP - 1)) begin
            state_n = (V_BACK > 0) ? VS_TAIL : GAP;
            v_n     = '0;
          end else begin
            v_n = v_cnt + 1'b1;
          end
        end else begin
          h_n = h_cnt + 1'b1;
        end
      end
      VS_TAIL: begin
        if (line_end) begin
          h_n = '0;
          if (v_cnt == VW'(V_BACK - 1)) begin
            state_n = GAP;
            v_n     = '0;
          end else begin
            v_n = v_cnt + 1'b1;
          end
        end else begin
          h_n = h_cnt + 1'b1;
        end
      end
      GAP: begin
        if (h_cnt == HW'(FRAME_GAP - 1)) begin
          h_n     = '0;
          v_n     = '0;
          state_n = continuous ? VS_LEAD : IDLE;
        end else begin
          h_n = h_cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        h_n     = '0;
        v_n     = '0;
      end
    endcase
  end

  // Output decode is done on the next-state view so every output is a flop.
  // A word is requested two cycles ahead of its first pixel: the first word of
  // a line from the tail of the preceding lead-in line or blanking interval.
  always_comb begin
    vsync_n    = (state_n == VS_LEAD) || (state_n == ACTIVE) || (state_n == VS_TAIL);
    href_n     = (state_n == ACTIVE) && (h_n < HW'(IMG_HDISP));
    word_first = href_n && (h_n[3:0] == 4'd0);
    rd_n       = ((state_n == VS_LEAD) && (v_n == VW'(V_FRONT - 1)) && (h_n == HW'(LINE - 2))) ||
                 ((state_n == ACTIVE) && (h_n == HW'(LINE - 2)) && (v_n != VW'(IMG_VDISP - 1))) ||
                 ((state_n == ACTIVE) && (h_n < HW'(IMG_HDISP - 2)) && (h_n[3:0] == 4'd14));
    done_n     = (state_n == GAP) && (state != GAP);
    new_frame  = (state_n == VS_LEAD) && (state != VS_LEAD);
    ptr_cur    = new_frame ? '0 : ptr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      h_cnt            <= '0;
      v_cnt            <= '0;
      ptr              <= '0;
      sh               <= '0;
      busy             <= 1'b0;
      frame_done       <= 1'b0;
      frame_cnt        <= '0;
      rd_en            <= 1'b0;
      rd_addr          <= '0;
      post_frame_vsync <= 1'b0;
      post_frame_href  <= 1'b0;
      post_frame_clken <= 1'b0;
      post_img_Bit     <= 1'b0;
    end else begin
      state            <= state_n;
      h_cnt            <= h_n;
      v_cnt            <= v_n;
      busy             <= (state_n != IDLE);
      frame_done       <= done_n;
      post_frame_vsync <= vsync_n;
      post_frame_href  <= href_n;
      post_frame_clken <= href_n;
      rd_en            <= rd_n;
      if (done_n) frame_cnt <= frame_cnt + 8'd1;
      if (rd_n) begin
        rd_addr <= ptr_cur;
        ptr     <= ptr_cur + 1'b1;
      end else begin
        ptr <= ptr_cur;
      end
      // rd_data is valid in the cycle before a word's first pixel, so it is
      // loaded straight into the shifter at that edge; bit 0 leaves first.
      if (word_first) begin
        sh           <= rd_data;
        post_img_Bit <= rd_data[0];
      end else if (href_n) begin
        sh           <= sh >> 1;
        post_img_Bit <= sh[1];
      end else begin
        post_img_Bit <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vip_bin_frame_source.sv
// Self-checking bench for vip_bin_frame_source: random bitmaps, per-cycle
// comparison against a frame-timing model computed from absolute cycle positions.
module tb_vip_bin_frame_source;

  localparam int HD    = 32;
  localparam int VD    = 4;
  localparam int HB    = 4;
  localparam int VF    = 1;
  localparam int VB    = 1;
  localparam int FG    = 3;
  localparam int AW    = 15;
  localparam int LINE  = HD + HB;
  localparam int WPL   = HD / 16;
  localparam int VTOT  = (VF + VD + VB) * LINE;
  localparam int FRAME = VTOT + FG;
  localparam int NW    = VD * WPL;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          continuous;
  logic          busy;
  logic          frame_done;
  logic [7:0]    frame_cnt;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [15:0]   rd_data = '0;
  logic          post_frame_vsync;
  logic          post_frame_href;
  logic          post_frame_clken;
  logic          post_img_Bit;
  logic [2:0]    dbg_state;

  logic [15:0] mem [NW];
  int checks = 0;
  int errors = 0;
  int cur_r  = 0;
  int fc_base = 0;

  // clock / reset
  always #5 clk = ~clk;

  vip_bin_frame_source #(
    .IMG_HDISP(HD), .IMG_VDISP(VD), .H_BLANK(HB), .V_FRONT(VF),
    .V_BACK(VB), .FRAME_GAP(FG), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous),
    .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .post_frame_vsync(post_frame_vsync), .post_frame_href(post_frame_href),
    .post_frame_clken(post_frame_clken), .post_img_Bit(post_img_Bit),
    .dbg_state(dbg_state)
  );

  // synchronous bitmap RAM: data valid the cycle after rd_en
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[int'(rd_addr) % NW];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s r=%0d got=%0h exp=%0h", tag, cur_r, got, exp);
    end
  endtask

  function automatic logic [6:0] dut_sig();
    return {busy, frame_done, post_frame_vsync, post_frame_href,
            post_frame_clken, post_img_Bit, rd_en};
  endfunction

  // Reference: r cycles after the start pulse, nf frames requested.
  // sig = {busy, frame_done, vsync, href, clken, bit, rd_en}
  task automatic model(input int r, input int nf, output logic [6:0] sig,
                       output int done_frames, output int addr);
    int k, ph, ln, col, ph2, ln2, col2;
    logic b_busy, b_done, b_vs, b_href, b_bit, b_rd;
    sig = '0; done_frames = 0; addr = 0;
    if (r >= 1) begin
      k  = (r - 1) / FRAME;
      ph = (r - 1) % FRAME + 1;
      if (k >= nf) begin
        done_frames = nf;
      end else begin
        done_frames = k + ((ph > VTOT) ? 1 : 0);
        b_busy = 1'b1;
        b_done = (ph == VTOT + 1);
        b_vs   = (ph <= VTOT);
        ln     = (ph - 1) / LINE;
        col    = (ph - 1) % LINE;
        b_href = b_vs && ln >= VF && ln < VF + VD && col < HD;
        b_bit  = b_href ? mem[(ln - VF) * WPL + col / 16][col % 16] : 1'b0;
        ph2    = ph + 2;
        ln2    = (ph2 - 1) / LINE;
        col2   = (ph2 - 1) % LINE;
        b_rd   = (ph2 <= VTOT) && ln2 >= VF && ln2 < VF + VD && col2 < HD && (col2 % 16 == 0);
        if (b_rd) addr = (ln2 - VF) * WPL + col2 / 16;
        sig = {b_busy, b_done, b_vs, b_href, b_href, b_bit, b_rd};
      end
    end
  endtask

  task automatic check_cycle(input int r, input int nf);
    logic [6:0] sig;
    int df, addr;
    cur_r = r;
    model(r, nf, sig, df, addr);
    chk("sig", 32'(dut_sig()), 32'(sig));
    chk("frame_cnt", 32'(frame_cnt), 32'(8'(fc_base + df)));
    if (sig[0]) chk("rd_addr", 32'(rd_addr), 32'(addr));
  endtask

  // driver: entered and left #1 after a rising edge
  task automatic run_session(input int nf, input int drop_at, input int p1, input int p2);
    for (int r = 0; r <= nf * FRAME + 3; r++) begin
      start      = (r == 0) || (r == p1) || (r == p2);
      continuous = (r < drop_at);
      @(negedge clk);
      check_cycle(r, nf);
      @(posedge clk); #1;
    end
    start = 1'b0;
    continuous = 1'b0;
    fc_base += nf;
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    chk(tag, {25'd0, dut_sig()}, 32'd0);
    chk({tag, "_cnt"}, 32'(frame_cnt), 32'(8'(fc_base)));
    @(posedge clk); #1;
  endtask

  task automatic fill_random();
    for (int i = 0; i < NW; i++) mem[i] = 16'($urandom_range(0, 16'hffff));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; continuous = 1'b0;
    fill_random();
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    @(negedge clk);
    chk("reset_out", {25'd0, dut_sig()}, 32'd0);
    chk("reset_cnt", 32'(frame_cnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    for (int i = 0; i < 100; i++) check_idle("idle");

    // single frame, random bitmap, start pulses while busy ignored
    run_session(1, 0, 10, 100);

    // directed corner pixels
    for (int i = 0; i < NW; i++) mem[i] = 16'h0000;
    mem[0] = 16'h0001;
    mem[1] = 16'h8000;
    run_session(1, 0, -1, -1);

    // back-to-back frames, continuous dropped mid second frame
    fill_random();
    run_session(2, 300, -1, -1);

    // synchronous reset mid-line, start coincident with reset ignored
    fill_random();
    for (int r = 0; r <= 50; r++) begin
      start = (r == 0);
      if (r == 50) begin
        rst = 1'b1;
        start = 1'b1;
      end
      @(negedge clk);
      check_cycle(r, 1);
      @(posedge clk); #1;
    end
    rst = 1'b0; start = 1'b0;
    fc_base = 0;
    for (int r = 51; r < 60; r++) begin
      cur_r = r;
      check_idle("post_rst");
    end
    run_session(1, 0, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
